// File: rtl/cu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// cu_sequencer_pkg
//   Shared definitions for the control-unit sequencer:
//     - cu_state_e : 4-bit state encodings. They are zero-extended to the
//                    STATE_W-wide state register.
//     - IR_*       : bit positions of the instruction fields the sequencer
//                    decodes.
//     - TD_*       : typeData access-size codes.
//   No ports (package).
// ---------------------------------------------------------------------------
package cu_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_DEC  = 4'd4,
    S_DP   = 4'd5,
    S_LS0  = 4'd6,
    S_LS1  = 4'd7,
    S_LS2  = 4'd8,
    S_BR   = 4'd9,
    S_TRAP = 4'd10
  } cu_state_e;

  // Instruction field positions
  localparam int IR_CLS_HI = 27;  // instruction class ir[27:25]
  localparam int IR_CLS_LO = 25;
  localparam int IR_OP_HI  = 24;  // top two opcode bits ir[24:23]
  localparam int IR_OP_LO  = 23;
  localparam int IR_B      = 22;  // byte access
  localparam int IR_L      = 20;  // load / set-flags

  // Access-size codes
  localparam logic [1:0] TD_WORD = 2'b10;
  localparam logic [1:0] TD_BYTE = 2'b00;

endpackage

// File: rtl/cu_sequencer_state_reg.sv
// ---------------------------------------------------------------------------
// cu_state_reg
//   State register of the control-unit sequencer. On an asynchronous clear it
//   returns to the all-zero encoding (S_IDLE). Otherwise it loads the next
//   state on every rising clock edge.
//   Ports:
//     clk_i  in  1        clock, rising edge
//     rst_i  in  1        async active-high clear
//     d_i    in  STATE_W  next state
//     q_o    out STATE_W  current state
// ---------------------------------------------------------------------------
module cu_state_reg #(
  parameter int STATE_W = 7
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [STATE_W-1:0] d_i,
  output logic [STATE_W-1:0] q_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_o <= '0;
    else       q_o <= d_i;
  end

endmodule

// File: rtl/cu_sequencer.sv
// ---------------------------------------------------------------------------
// cu_sequencer
//   Control-unit sequencer for the ARM-subset datapath. It combines the state
//   register, the next-state decoder and the Moore output decoder. It handles
//   fetch/load-store memory waits on MOC, condition-gated dispatch and a trap
//   state.
//   Optional feature: define CU_MOC_TIMEOUT_EN to trap after MOC_TIMEOUT wait
//   cycles without MOC. In the default build the sequencer waits on MOC
//   indefinitely and trap_cause is tied to 0.
//   Ports:
//     CLK        in   1        clock, rising edge
//     CLR        in   1        async active-high reset
//     ir         in   IR_W     current instruction
//     cond       in   1        condition-check result (used in S_DEC)
//     MOC        in   1        memory operation complete (used in S_F1/S_LS1)
//     state      out  STATE_W  current state (registered)
//     nextS      out  STATE_W  combinational next state
//     MARLd, MDRLd, IRLd, RFLd, FRLd  out  load strobes
//     MOV, RW    out  1        memory enable, RW=1 read / 0 write
//     typeData   out  2        2'b10 word, 2'b00 byte
//     trap       out  1        high in S_TRAP
//     trap_cause out  1        0 undefined instruction, 1 MOC timeout
// ---------------------------------------------------------------------------
module cu_sequencer
  import cu_sequencer_pkg::*;
#(
  parameter int STATE_W     = 7,
  parameter int IR_W        = 32,
  parameter int MOC_TIMEOUT = 15
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic [IR_W-1:0]    ir,
  input  logic               cond,
  input  logic               MOC,
  output logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] nextS,
  output logic               MARLd,
  output logic               MDRLd,
  output logic               IRLd,
  output logic               RFLd,
  output logic               FRLd,
  output logic               MOV,
  output logic               RW,
  output logic [1:0]         typeData,
  output logic               trap,
  output logic               trap_cause
);

  localparam logic [STATE_W-1:0] ST_IDLE = STATE_W'(S_IDLE);
  localparam logic [STATE_W-1:0] ST_F0   = STATE_W'(S_F0);
  localparam logic [STATE_W-1:0] ST_F1   = STATE_W'(S_F1);
  localparam logic [STATE_W-1:0] ST_F2   = STATE_W'(S_F2);
  localparam logic [STATE_W-1:0] ST_DEC  = STATE_W'(S_DEC);
  localparam logic [STATE_W-1:0] ST_DP   = STATE_W'(S_DP);
  localparam logic [STATE_W-1:0] ST_LS0  = STATE_W'(S_LS0);
  localparam logic [STATE_W-1:0] ST_LS1  = STATE_W'(S_LS1);
  localparam logic [STATE_W-1:0] ST_LS2  = STATE_W'(S_LS2);
  localparam logic [STATE_W-1:0] ST_BR   = STATE_W'(S_BR);
  localparam logic [STATE_W-1:0] ST_TRAP = STATE_W'(S_TRAP);

  logic [STATE_W-1:0] state_q, state_d;
  logic               timeout_hit;

  // Instruction bits the sequencer never decodes (condition field, operands)
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[IR_W-1:IR_CLS_HI], ir[21], ir[19:0]};

  cu_state_reg #(.STATE_W(STATE_W)) u_state_reg (
    .clk_i (CLK),
    .rst_i (CLR),
    .d_i   (state_d),
    .q_o   (state_q)
  );

`ifdef CU_MOC_TIMEOUT_EN
  localparam int CNT_W = $clog2(MOC_TIMEOUT) + 1;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             in_wait;
  logic             cause_q;

  assign in_wait     = (state_q == ST_F1) || (state_q == ST_LS1);
  // Count only MOC-low wait cycles. Any other cycle (including leaving the
  // wait state) restarts the count for the next memory phase.
  assign wait_cnt_d  = (in_wait && !MOC) ? wait_cnt_q + CNT_W'(1) : '0;
  // MOC high on the final cycle is not a timeout, so the normal transition wins.
  assign timeout_hit = in_wait && !MOC && (wait_cnt_q == CNT_W'(MOC_TIMEOUT - 1));

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      wait_cnt_q <= '0;
      cause_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      // S_TRAP is only left through CLR, so the cause only ever needs setting
      cause_q    <= cause_q | timeout_hit;
    end
  end

  assign trap_cause = cause_q;
`else
  assign timeout_hit = 1'b0;
  assign trap_cause  = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_F0;
      ST_F0:   state_d = ST_F1;
      ST_F1: begin
        if (MOC)              state_d = ST_F2;
        else if (timeout_hit) state_d = ST_TRAP;
      end
      ST_F2:   state_d = ST_DEC;
      ST_DEC: begin
        if (!cond) begin
          state_d = ST_F0;
        end else begin
          casez (ir[IR_CLS_HI:IR_CLS_LO])
            3'b00?:  state_d = ST_DP;
            3'b01?:  state_d = ST_LS0;
            3'b101:  state_d = ST_BR;
            default: state_d = ST_TRAP;
          endcase
        end
      end
      ST_DP:   state_d = ST_F0;
      ST_LS0:  state_d = ST_LS1;
      ST_LS1: begin
        if (MOC)              state_d = ir[IR_L] ? ST_LS2 : ST_F0;
        else if (timeout_hit) state_d = ST_TRAP;
      end
      ST_LS2:  state_d = ST_F0;
      ST_BR:   state_d = ST_F0;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
  end

  // Moore output decode from the registered state (ir only qualifies it)
  always_comb begin
    MARLd    = 1'b0;
    MDRLd    = 1'b0;
    IRLd     = 1'b0;
    RFLd     = 1'b0;
    FRLd     = 1'b0;
    MOV      = 1'b0;
    RW       = 1'b0;
    typeData = TD_WORD;
    trap     = 1'b0;
    case (state_q)
      ST_F0: begin
        MARLd = 1'b1;
        RFLd  = 1'b1;           // PC <- PC + 4
      end
      ST_F1: begin
        MOV   = 1'b1;
        RW    = 1'b1;
        MDRLd = 1'b1;
      end
      ST_F2:   IRLd = 1'b1;
      ST_DP: begin
        // Opcodes 10xx (TST/TEQ/CMP/CMN) only update flags
        RFLd = ~(ir[IR_OP_HI:IR_OP_LO] == 2'b10);
        FRLd = ir[IR_L];
      end
      ST_LS0:  MARLd = 1'b1;
      ST_LS1: begin
        MOV      = 1'b1;
        RW       = ir[IR_L];
        MDRLd    = ir[IR_L];
        typeData = ir[IR_B] ? TD_BYTE : TD_WORD;
      end
      ST_LS2:  RFLd = 1'b1;
      ST_BR:   RFLd = 1'b1;     // PC <- branch target
      ST_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;
  assign nextS = state_d;

endmodule

// File: tb/tb_cu_sequencer.sv
module tb_cu_sequencer;

  localparam int STATE_W = 7;
  localparam int IR_W    = 32;
  localparam int TO      = 15;
  localparam logic [1:0] WORD = 2'b10;
  localparam logic [1:0] BYTE = 2'b00;

  logic               CLK = 1'b0;
  logic               CLR = 1'b0;
  logic [IR_W-1:0]    ir  = '0;
  logic               cond = 1'b0;
  logic               MOC  = 1'b0;
  logic [STATE_W-1:0] state, nextS;
  logic               MARLd, MDRLd, IRLd, RFLd, FRLd, MOV, RW;
  logic [1:0]         typeData;
  logic               trap, trap_cause;
  logic [10:0]        dut_outs;

  int vectors = 0;
  int errors  = 0;

  cu_sequencer #(.STATE_W(STATE_W), .IR_W(IR_W), .MOC_TIMEOUT(TO)) dut (
    .CLK(CLK), .CLR(CLR), .ir(ir), .cond(cond), .MOC(MOC),
    .state(state), .nextS(nextS),
    .MARLd(MARLd), .MDRLd(MDRLd), .IRLd(IRLd), .RFLd(RFLd), .FRLd(FRLd),
    .MOV(MOV), .RW(RW), .typeData(typeData),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 CLK = ~CLK;

  assign dut_outs = {MARLd, MDRLd, IRLd, RFLd, FRLd, MOV, RW, typeData, trap, trap_cause};

  // Expected per-cycle behaviour: state, strobes and the MOC value to apply
  typedef struct {
    int          st;
    int          nxt;
    logic [10:0] outs;
    logic        moc;
  } step_t;

  step_t q[$];
  bit    last_trapped;

  function automatic logic [10:0] mk(input bit mar, input bit mdr, input bit irl,
                                     input bit rf, input bit fr, input bit mov,
                                     input bit rw, input logic [1:0] td,
                                     input bit tr, input bit cs);
    return {mar, mdr, irl, rf, fr, mov, rw, td, tr, cs};
  endfunction

  task automatic push(input int st, input logic [10:0] outs, input logic moc);
    step_t s;
    s.st = st; s.nxt = -1; s.outs = outs; s.moc = moc;
    q.push_back(s);
  endtask

  task automatic add_trap(input bit cause, input int n);
    for (int i = 0; i < n; i++) push(10, mk(0,0,0,0,0,0,0,WORD,1,cause), 1'($urandom_range(0,1)));
  endtask

  // A memory phase lasting w MOC-low cycles, then one MOC-high cycle
  task automatic mem_wait(input int st, input logic [10:0] outs, input int w, output bit to);
    to = 1'b0;
    for (int i = 0; i < w; i++) begin
      push(st, outs, 1'b0);
`ifdef CU_MOC_TIMEOUT_EN
      if (i == TO - 1) begin
        to = 1'b1;
        return;
      end
`endif
    end
    push(st, outs, 1'b1);
  endtask

  // Expected cycle sequence of one instruction, starting from fetch
  task automatic build_instr(input logic [31:0] ins, input bit c, input int fw,
                             input int mw, input int ntrap);
    bit to;
    bit ld, byt;
    logic [3:0] opc;
    push(1, mk(1,0,0,1,0,0,0,WORD,0,0), 1'($urandom_range(0,1)));
    mem_wait(2, mk(0,1,0,0,0,1,1,WORD,0,0), fw, to);
    if (to) begin add_trap(1'b1, ntrap); return; end
    push(3, mk(0,0,1,0,0,0,0,WORD,0,0), 1'($urandom_range(0,1)));
    push(4, mk(0,0,0,0,0,0,0,WORD,0,0), 1'($urandom_range(0,1)));
    if (!c) return;
    opc = ins[24:21];
    ld  = ins[20];
    byt = ins[22];
    case (ins[27:25])
      3'b000, 3'b001: begin
        // comparison opcodes 8..11 write no register
        push(5, mk(0,0,0, !(opc >= 4'd8 && opc <= 4'd11), ins[20], 0,0,WORD,0,0),
             1'($urandom_range(0,1)));
      end
      3'b010, 3'b011: begin
        push(6, mk(1,0,0,0,0,0,0,WORD,0,0), 1'($urandom_range(0,1)));
        mem_wait(7, mk(0,ld,0,0,0,1,ld, byt ? BYTE : WORD, 0,0), mw, to);
        if (to) begin add_trap(1'b1, ntrap); return; end
        if (ld) push(8, mk(0,0,0,1,0,0,0,WORD,0,0), 1'($urandom_range(0,1)));
      end
      3'b101: push(9, mk(0,0,0,1,0,0,0,WORD,0,0), 1'($urandom_range(0,1)));
      default: add_trap(1'b0, ntrap);
    endcase
  endtask

  // Apply the queued cycles and check state, strobes and next state.
  // Entered just after a falling edge; final_nxt < 0 means default successor.
  task automatic play(input int final_nxt);
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      if (i + 1 < n)            q[i].nxt = q[i+1].st;
      else if (final_nxt >= 0)  q[i].nxt = final_nxt;
      else                      q[i].nxt = (q[i].st == 10) ? 10 : 1;
    end
    last_trapped = (n > 0) && (q[n-1].st == 10);
    for (int i = 0; i < n; i++) begin
      MOC = q[i].moc;
      #1;
      vectors++;
      if (state !== STATE_W'(q[i].st)) begin
        errors++;
        $display("FAIL state step %0d ir=%h: got %0d want %0d", i, ir, state, q[i].st);
      end
      vectors++;
      if (dut_outs !== q[i].outs) begin
        errors++;
        $display("FAIL strobes step %0d state %0d ir=%h: got %b want %b",
                 i, q[i].st, ir, dut_outs, q[i].outs);
      end
      vectors++;
      if (nextS !== STATE_W'(q[i].nxt)) begin
        errors++;
        $display("FAIL nextS step %0d state %0d ir=%h MOC=%b: got %0d want %0d",
                 i, q[i].st, ir, MOC, nextS, q[i].nxt);
      end
      @(negedge CLK);
    end
    q.delete();
  endtask

  // Asynchronous clear away from any clock edge; also used to abort mid-instruction
  task automatic do_reset(input string why);
    #2 CLR = 1'b1;
    #1;
    vectors++;
    if (state !== '0) begin
      errors++;
      $display("FAIL %s immediate state: got %0d want 0", why, state);
    end
    vectors++;
    if (dut_outs !== mk(0,0,0,0,0,0,0,WORD,0,0)) begin
      errors++;
      $display("FAIL %s immediate strobes: got %b want %b", why, dut_outs, mk(0,0,0,0,0,0,0,WORD,0,0));
    end
    @(negedge CLK);
    vectors++;
    if (state !== '0) begin
      errors++;
      $display("FAIL %s held state: got %0d want 0", why, state);
    end
    CLR = 1'b0;
    push(0, mk(0,0,0,0,0,0,0,WORD,0,0), 1'($urandom_range(0,1)));
  endtask

  task automatic run(input logic [31:0] ins, input bit c, input int fw, input int mw, input int ntrap);
    ir   = ins;
    cond = c;
    build_instr(ins, c, fw, mw, ntrap);
    play(-1);
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_directed();
    run(32'hE2010000, 1'b1, 0, 0, 0);   // data processing, writes Rd
    run(32'hE5910000, 1'b1, 0, 0, 0);   // LDR word
    run(32'hE5C10000, 1'b1, 0, 0, 0);   // STRB
    run(32'hEA000000, 1'b0, 0, 0, 0);   // branch, condition fails
    run(32'hEA000000, 1'b1, 0, 0, 0);   // branch taken
    run(32'hE1500000, 1'b1, 1, 0, 0);   // CMP with S: flags only
    run(32'hEC000000, 1'b1, 0, 0, 20);  // undefined -> trap, held
    do_reset("trap_clear");
  endtask

  task automatic test_random();
    int k, u;
    logic [2:0] cls;
    logic [31:0] ins;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      if (k < 4)      cls = {2'b00, 1'($urandom_range(0,1))};
      else if (k < 7) cls = {2'b01, 1'($urandom_range(0,1))};
      else if (k < 9) cls = 3'b101;
      else begin
        u = $urandom_range(0, 2);
        cls = (u == 0) ? 3'b100 : (u == 1) ? 3'b110 : 3'b111;
      end
      ins = {4'hE, cls, 25'($urandom)};
      run(ins, ($urandom_range(0,4) != 0), $urandom_range(0,10), $urandom_range(0,10), 3);
      if (last_trapped) do_reset("random_trap_clear");
    end
  endtask

  task automatic test_back_to_back();
    // Long fetch wait followed by a long load wait: each phase counts separately
    run(32'hE2010000, 1'b1, TO-1, 0, 0);
    run(32'hE5910000, 1'b1, TO-1, TO-1, 0);
    run(32'hE5C10000, 1'b1, 7, 9, 0);
  endtask

  task automatic test_timeout();
    run(32'hE2010000, 1'b1, TO, 0, 5);    // fetch wait reaches the limit
    if (last_trapped) do_reset("fetch_timeout_clear");
    run(32'hE5910000, 1'b1, 2, TO, 5);    // load wait reaches the limit
    if (last_trapped) do_reset("load_timeout_clear");
    run(32'hE5C10000, 1'b1, 0, TO + 5, 5);
    if (last_trapped) do_reset("store_timeout_clear");
  endtask

  task automatic test_clr_midwait();
    ir = 32'hE5910000;
    cond = 1'b1;
    push(1, mk(1,0,0,1,0,0,0,WORD,0,0), 1'b0);
    for (int i = 0; i < 8; i++) push(2, mk(0,1,0,0,0,1,1,WORD,0,0), 1'b0);
    play(2);
    do_reset("clr_fetch_wait");
    push(1, mk(1,0,0,1,0,0,0,WORD,0,0), 1'b0);
    push(2, mk(0,1,0,0,0,1,1,WORD,0,0), 1'b1);
    push(3, mk(0,0,1,0,0,0,0,WORD,0,0), 1'b0);
    push(4, mk(0,0,0,0,0,0,0,WORD,0,0), 1'b0);
    push(6, mk(1,0,0,0,0,0,0,WORD,0,0), 1'b0);
    for (int i = 0; i < 10; i++) push(7, mk(0,1,0,0,0,1,1,WORD,0,0), 1'b0);
    play(7);
    do_reset("clr_load_wait");
    // The wait count must restart after the abort
    run(32'hE5910000, 1'b1, TO-1, 1, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_timeout();
    test_clr_midwait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
